// File: rtl/lcd_responder_if.sv
// Character-LCD bus between the SoC output registers and the
// board-side display responder, plus the display-buffer peek port.
interface lcd_responder_if;
  logic [7:0] lcd_data;
  logic [1:0] lcd_ctrl;
  logic       lcd_enable;
  logic [7:0] lcd_rdata;
  logic       busy;
  logic       overrun;
  logic       display_on;
  logic       char_valid;
  logic [7:0] char_out;
  logic [4:0] disp_idx;
  logic [7:0] disp_char;

  modport master (
    output lcd_data, lcd_ctrl, lcd_enable, disp_idx,
    input  lcd_rdata, busy, overrun, display_on,
    input  char_valid, char_out, disp_char
  );

  modport slave (
    input  lcd_data, lcd_ctrl, lcd_enable, disp_idx,
    output lcd_rdata, busy, overrun, display_on,
    output char_valid, char_out, disp_char
  );
endinterface

// File: rtl/lcd_responder.sv
// HD44780-style 2x16 character LCD responder: executes bus
// transactions on falling edges of lcd_enable.
module lcd_responder #(
  parameter int BUSY_CYCLES = 4
) (
  input logic           clk,
  input logic           rst,
  lcd_responder_if.slave bus
);
  localparam int CW = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(BUSY_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_CLEAR
  } state_t;

  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [4:0]    r_clr, w_clr_nx;
  logic          r_s1, r_s2, r_hist;
  logic [4:0]    r_ac;
  logic          r_id;
  logic          r_disp;
  logic          r_ovr;
  logic          r_cv;
  logic [7:0]    r_co;
  logic [7:0]    r_rdata;
  logic [7:0]    r_buf [32];

  logic       w_fall, w_busy, w_wr, w_acc;
  logic       w_instr, w_dwr, w_drd, w_clr_end;
  logic [4:0] w_ac_step;
  logic [6:0] w_addr;
  logic [7:0] w_lead;
  logic [7:0] w_d;

  assign w_d       = bus.lcd_data;
  assign w_fall    = r_hist & ~r_s2;
  assign w_busy    = (r_state != S_IDLE);
  assign w_wr      = w_fall & ~bus.lcd_ctrl[0];
  assign w_acc     = w_wr & ~w_busy;
  assign w_instr   = w_acc & ~bus.lcd_ctrl[1];
  assign w_dwr     = w_acc & bus.lcd_ctrl[1];
  assign w_drd     = w_fall & (bus.lcd_ctrl == 2'b11);
  assign w_clr_end = (r_state == S_CLEAR) && (r_clr == 5'd31);
  assign w_ac_step = r_id ? r_ac + 5'd1 : r_ac - 5'd1;
  assign w_addr    = {1'b0, r_ac[4], 2'b00, r_ac[3:0]};

  // One-hot of the highest set bit, so the decode below is truly unique
  always_comb begin
    w_lead = 8'h00;
    for (int i = 0; i < 8; i++)
      if (w_d[i]) w_lead = 8'(1 << i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_hist <= 1'b0;
    end else begin
      r_s1   <= bus.lcd_enable;
      r_s2   <= r_s1;
      r_hist <= r_s2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
      r_clr   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_clr   <= w_clr_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_clr_nx   = r_clr;
    unique case (r_state)
      S_IDLE: begin
        if (w_instr && w_d == 8'h01) begin
          w_state_nx = S_CLEAR;
          w_clr_nx   = '0;
        end else if (w_acc) begin
          w_state_nx = S_EXEC;
          w_cnt_nx   = LOAD;
        end
      end
      S_EXEC: begin
        if (r_cnt == '0) w_state_nx = S_IDLE;
        else             w_cnt_nx   = r_cnt - 1'b1;
      end
      S_CLEAR: begin
        w_clr_nx = r_clr + 5'd1;
        if (w_clr_end) begin
          w_state_nx = S_EXEC;
          w_cnt_nx   = LOAD;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ac    <= '0;
      r_id    <= 1'b1;
      r_disp  <= 1'b0;
      r_ovr   <= 1'b0;
      r_cv    <= 1'b0;
      r_co    <= '0;
      r_rdata <= '0;
    end else begin
      r_cv <= w_dwr;
      if (w_dwr) r_co <= w_d;
      if (w_wr && w_busy) r_ovr <= 1'b1;
      if (w_clr_end) begin
        r_ac <= '0;
        r_id <= 1'b1;
      end else if (w_dwr || w_drd) begin
        r_ac <= w_ac_step;
      end else if (w_instr) begin
        unique case (1'b1)
          w_lead[7]: if (w_d[5:4] == 2'b00) r_ac <= {w_d[6], w_d[3:0]};
          w_lead[3]: r_disp <= w_d[2];
          w_lead[2]: r_id   <= w_d[1];
          w_lead[1]: r_ac   <= '0;
          default: ;
        endcase
      end
      unique case (bus.lcd_ctrl)
        2'b01:   r_rdata <= {w_busy, w_addr};
        2'b11:   r_rdata <= r_buf[r_ac];
        default: r_rdata <= 8'h00;
      endcase
    end
  end

  // Buffer has no reset: the CLEAR walk after reset fills it
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) r_buf[r_clr] <= 8'h20;
    else if (w_dwr)         r_buf[r_ac]  <= w_d;
  end

  assign bus.lcd_rdata  = r_rdata;
  assign bus.busy       = w_busy;
  assign bus.overrun    = r_ovr;
  assign bus.display_on = r_disp;
  assign bus.char_valid = r_cv;
  assign bus.char_out   = r_co;
  assign bus.disp_char  = r_buf[bus.disp_idx];
endmodule

// File: tb/tb_lcd_responder.sv
// Self-checking bench for lcd_responder: bus tasks drive
// transactions, a queue scoreboards char_valid/char_out.
module tb_lcd_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lcd_responder_if bus ();

  lcd_responder #(.BUSY_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] exp_q [$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.char_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("char_extra", 1, 0);
      else chk("char_out", bus.char_out, exp_q.pop_front());
    end
  end

  task automatic strobe(input logic [1:0] c, input logic [7:0] d);
    @(negedge clk);
    bus.lcd_ctrl   = c;
    bus.lcd_data   = d;
    bus.lcd_enable = 1'b1;
    repeat (2) @(negedge clk);
    bus.lcd_enable = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (bus.busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) chk("idle_timeout", 1, 0);
  endtask

  task automatic wr_instr(input logic [7:0] d);
    strobe(2'b00, d);
    wait_idle();
  endtask

  task automatic wr_data(input logic [7:0] d);
    exp_q.push_back(d);
    strobe(2'b10, d);
    wait_idle();
  endtask

  task automatic status(input string tag, input logic [7:0] e);
    strobe(2'b01, 8'h00);
    chk(tag, bus.lcd_rdata, e);
  endtask

  task automatic peek(input string tag, input logic [4:0] idx,
                      input logic [7:0] e);
    bus.disp_idx = idx;
    #1;
    chk(tag, bus.disp_char, e);
  endtask

  initial begin
    int  k;
    logic saw;
    bus.lcd_enable = 1'b0;
    bus.lcd_ctrl   = 2'b00;
    bus.lcd_data   = 8'h00;
    bus.disp_idx   = 5'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 1);
    chk("rst_ovr", bus.overrun, 0);
    chk("rst_rdata", bus.lcd_rdata, 0);
    chk("rst_disp", bus.display_on, 0);
    chk("rst_cv", bus.char_valid, 0);
    rst = 1'b0;

    k = 0;
    while (k < 100) begin
      @(negedge clk);
      k++;
      if (!bus.busy) break;
    end
    chk("rst_busy_len", k, 36);
    repeat (4) @(negedge clk);
    chk("fill_busy", bus.busy, 0);
    chk("fill_ovr", bus.overrun, 0);
    for (int i = 0; i < 32; i++) peek("fill", 5'(i), 8'h20);

    wr_instr(8'h0C);
    chk("disp_on", bus.display_on, 1);
    wr_data(8'h48);
    wr_data(8'h69);
    peek("hi_0", 5'd0, 8'h48);
    peek("hi_1", 5'd1, 8'h69);
    status("st_hi", 8'h02);

    wr_instr(8'hCF);
    wr_data(8'h41);
    peek("wrap_31", 5'd31, 8'h41);
    status("st_wrap", 8'h00);

    wr_instr(8'h8F);
    wr_data(8'h42);
    peek("line_15", 5'd15, 8'h42);
    status("st_line2", 8'h40);

    wr_instr(8'h04);
    wr_instr(8'h80);
    wr_data(8'h58);
    peek("dec_0", 5'd0, 8'h58);
    status("st_dec", 8'h4F);

    exp_q.push_back(8'h31);
    @(negedge clk);
    bus.lcd_ctrl   = 2'b10;
    bus.lcd_data   = 8'h31;
    bus.lcd_enable = 1'b1;
    repeat (2) @(negedge clk);
    bus.lcd_enable = 1'b0;
    @(negedge clk);
    bus.lcd_enable = 1'b1;
    @(negedge clk);
    bus.lcd_enable = 1'b0;
    @(negedge clk);
    bus.lcd_data   = 8'h32;
    repeat (5) @(negedge clk);
    wait_idle();
    peek("ovr_31", 5'd31, 8'h31);
    peek("ovr_30", 5'd30, 8'h20);
    chk("ovr_set", bus.overrun, 1);

    wr_instr(8'h06);
    wr_instr(8'h80);
    wr_instr(8'h95);
    status("st_ign", 8'h00);

    @(negedge clk);
    bus.lcd_ctrl = 2'b11;
    @(negedge clk);
    chk("rd_data", bus.lcd_rdata, 8'h58);
    saw = 1'b0;
    bus.lcd_enable = 1'b1;
    repeat (2) @(negedge clk);
    bus.lcd_enable = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.busy) saw = 1'b1;
    end
    chk("rd_nobusy", saw, 0);
    status("st_rd", 8'h01);

    repeat (5) @(negedge clk);
    chk("ovr_sticky", bus.overrun, 1);
    chk("q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
